mcpu_soc_audio_sched: RTL and testbench
=======================================

// Module: mcpu_soc_audio_sched
// PURPOSE
//  Stream controller for the I2S/left-justified audio output path. Buffers 32-bit stereo samples
//  from a requester (CPU store path or DMA) in a FIFO and generates mclk/bclk/lrclk. Serializes
//  one frame per sample, schedules FIFO pops at frame boundaries, and sequences start, stop and
//  underrun. Replaces free-running tone generation; sits between the SoC bus glue and ext_audio_* pins.
// PARAMETERS
//  DEPTH        16  FIFO entries; power of two, >=4
//  MCLK_HALF     4  core clocks per mclk half-period
//  BCLK_HALF    16  core clocks per bclk half-period; must be a multiple of MCLK_HALF
//  START_LEVEL   4  FIFO level required to leave PRIME; 1..DEPTH
//  LOW_WATER     4  dma_req asserted while level <= LOW_WATER
// PORTS
//  clkrst_core_clk    in   1   core clock; all logic on posedge
//  clkrst_core_rst    in   1   synchronous reset, active-high
//  cfg_enable         in   1   level: 1 = play, 0 = stop at next frame boundary
//  smp_valid          in   1   sample offered
//  smp_data           in   32  [31:16] left, [15:0] right; two's complement
//  smp_ready          out  1   FIFO can accept (= !full)
//  fifo_level         out  $clog2(DEPTH)+1  entries held
//  dma_req            out  1   refill request
//  stat_running       out  1   state is RUN or STOP
//  stat_underrun      out  1   sticky underrun flag
//  stat_clr_underrun  in   1   one-cycle pulse; clears flag and counter
//  underrun_cnt       out  16  saturating count of underrun frames
//  ext_audio_mclk     out  1   codec master clock
//  ext_audio_bclk     out  1   bit clock
//  ext_audio_lrclk    out  1   0 = left slot, 1 = right slot
//  ext_audio_data     out  1   serial data, MSB first
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FIFO empty; state IDLE; counters and shift register 0.
//   - Reset is honoured in any state; mid-frame it drops the frame, no drain.
//  FIFO:
//   - Push when smp_valid & smp_ready. smp_ready is registered off full; it stays 0 when full,
//     even in a pop cycle.
//   - Pop decisions use the registered level. A push and pop on an empty FIFO in the same cycle
//     is an underrun; the pushed word is retained.
//   - Level updates the cycle after the push/pop.
//   - dma_req = cfg_enable & (fifo_level <= LOW_WATER), registered.
//  States:
//   - IDLE: pclk/mclk/bclk/lrclk/data held 0.
//     -> PRIME when cfg_enable=1.
//   - PRIME: mclk runs; bclk, lrclk and data held 0.
//     -> RUN when level >= START_LEVEL (pop sample 0 into the shift register that cycle).
//     -> IDLE if cfg_enable drops first.
//   - RUN: see Timing and Frame boundary.
//     -> STOP when cfg_enable=0 is sampled.
//   - STOP: finish the current frame.
//     -> IDLE at frame end with no pop. FIFO contents are preserved.
//  Timing (PRIME/RUN/STOP):
//   - Divider pcnt counts 0..2*BCLK_HALF-1 and wraps.
//   - ext_audio_mclk toggles every MCLK_HALF clocks, starting low on PRIME entry.
//   - ext_audio_bclk = (pcnt >= BCLK_HALF); it is held 0 in PRIME.
//   - bcnt (5 bits) increments at each pcnt wrap, 0..31 then wraps.
//   - ext_audio_lrclk = bcnt[4].
//   - ext_audio_data = left[15-bcnt[3:0]] if bcnt<16, else right[15-bcnt[3:0]].
//   - Left-justified, no one-bit delay. Data and lrclk change only on bclk falling edges.
//  Frame boundary (pcnt wrap with bcnt==31, RUN only):
//   - level>0: pop into the shift register.
//   - level==0: load 0, set stat_underrun, underrun_cnt += 1 (saturate at 16'hFFFF).
//     Playback continues; there is no return to PRIME.
//   - stat_clr_underrun in the same cycle as an underrun: the clear wins.
//  Latency:
//   - First bclk rising edge is BCLK_HALF clocks after entering RUN.
//   - A sample's MSB is on data from RUN entry (first sample), or from the wrap for later ones.
// TESTING
//  1. Reset, enable, push 4 samples {16'h7000,16'h8001} with defaults -> RUN after the 4th push.
//     Expect: 32 bclk per frame, lrclk low 16 bclk, left bits 0111_0000_0000_0000, right
//     1000_0000_0000_0001.
//  2. Push 4 samples then starve -> after frame 4, data=0, stat_underrun=1, underrun_cnt increments
//     once per 1024 clocks. Pulse stat_clr_underrun -> flag and count 0.
//  3. Push 16 with enable=0 -> smp_ready=0 at level 16, 17th push stalls.
//     Enable -> first pop at RUN entry, smp_ready=1 the cycle after the level drops.
//  4. Drop cfg_enable mid-frame (bcnt=7) -> frame completes all 32 bits, IDLE.
//     Remaining 3 entries preserved, all outputs 0.
//  5. Assert clkrst_core_rst at bcnt=20 -> next cycle all outputs 0, level 0, state IDLE.
//  6. Empty FIFO, push coincident with boundary -> underrun counted, level=1 after, dma_req=1.

Source files
------------

// File: rtl/mcpu_soc_audio_sched.sv
// ---------------------------------------------------------------------------
// mcpu_soc_audio_sched
//
// Audio output stream controller. Stereo samples (left in [31:16], right in
// [15:0]) are buffered in a FIFO and played out one sample per frame in
// left-justified format: 32 bit clocks per frame, 16 left-slot bits then 16
// right-slot bits, MSB first. The block generates mclk, bclk and lrclk itself,
// pops the FIFO at frame boundaries and sequences start-up (PRIME), stop
// (STOP finishes the current frame) and underrun (a silent frame is played).
//
// Ports
//   clkrst_core_clk     core clock, all logic on the rising edge
//   clkrst_core_rst     synchronous reset, active high
//   cfg_enable          1 = play, 0 = stop at the next frame boundary
//   smp_valid/smp_data  sample offer from CPU store path or DMA
//   smp_ready           FIFO can accept a sample this cycle
//   fifo_level          number of FIFO entries held
//   dma_req             refill request while the level is at or below LOW_WATER
//   stat_running        high in RUN and STOP
//   stat_underrun       sticky underrun flag
//   stat_clr_underrun   one-cycle pulse clearing the flag and the counter
//   underrun_cnt        saturating count of underrun frames
//   ext_audio_*         codec pins: mclk, bclk, lrclk (0 = left), data
// ---------------------------------------------------------------------------
module mcpu_soc_audio_sched #(
    parameter int DEPTH       = 16,
    parameter int MCLK_HALF   = 4,
    parameter int BCLK_HALF   = 16,
    parameter int START_LEVEL = 4,
    parameter int LOW_WATER   = 4
) (
    input  logic                   clkrst_core_clk,
    input  logic                   clkrst_core_rst,
    input  logic                   cfg_enable,
    input  logic                   smp_valid,
    input  logic [31:0]            smp_data,
    output logic                   smp_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   dma_req,
    output logic                   stat_running,
    output logic                   stat_underrun,
    input  logic                   stat_clr_underrun,
    output logic [15:0]            underrun_cnt,
    output logic                   ext_audio_mclk,
    output logic                   ext_audio_bclk,
    output logic                   ext_audio_lrclk,
    output logic                   ext_audio_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(2 * BCLK_HALF);
    localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_START = LW'(START_LEVEL);
    localparam logic [LW-1:0] LVL_LOW   = LW'(LOW_WATER);
    localparam logic [PW-1:0] PCNT_LAST = PW'(2 * BCLK_HALF - 1);
    localparam logic [PW-1:0] PCNT_HALF = PW'(BCLK_HALF);
    localparam logic [MW-1:0] MCNT_LAST = MW'(MCLK_HALF - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [4:0]    bcnt_q, bcnt_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic          mclk_q, mclk_d;
    logic [31:0]   sreg_q, sreg_d;
    logic          urun_q, urun_d;
    logic [15:0]   ucnt_q, ucnt_d;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ready_q, ready_d;
    logic          dma_q, dma_d;

    logic          push, pop, running, pcnt_wrap, frame_end;
    logic [31:0]   rd_data;

    assign running   = (state_q == ST_RUN) || (state_q == ST_STOP);
    assign pcnt_wrap = (pcnt_q == PCNT_LAST);
    assign frame_end = pcnt_wrap && (bcnt_q == 5'd31);
    assign rd_data   = mem[rd_ptr_q];

    // Sequencer, bit-clock divider and serializer.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d = state_q;
        pcnt_d  = pcnt_q;
        bcnt_d  = bcnt_q;
        mcnt_d  = mcnt_q;
        mclk_d  = mclk_q;
        sreg_d  = sreg_q;
        urun_d  = urun_q;
        ucnt_d  = ucnt_q;
        pop     = 1'b0;

        if (state_q != ST_IDLE) begin
            if (mcnt_q == MCNT_LAST) begin
                mcnt_d = '0;
                mclk_d = ~mclk_q;
            end else begin
                mcnt_d = mcnt_q + MW'(1);
            end
            pcnt_d = pcnt_wrap ? '0 : pcnt_q + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_enable) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                end else if (level_q >= LVL_START) begin
                    // Frame 0 starts here: divider realigned so the first bclk
                    // rise lands BCLK_HALF clocks later, MSB already on data.
                    state_d = ST_RUN;
                    pcnt_d  = '0;
                    bcnt_d  = '0;
                    sreg_d  = rd_data;
                    pop     = 1'b1;
                end
            end
            default: begin // ST_RUN, ST_STOP
                // Shifting on the pcnt wrap keeps data and lrclk changing only
                // on bclk falling edges.
                if (pcnt_wrap) begin
                    bcnt_d = bcnt_q + 5'd1;
                    sreg_d = {sreg_q[30:0], 1'b0};
                end
                if (frame_end) begin
                    if ((state_q == ST_RUN) && cfg_enable) begin
                        if (level_q != '0) begin
                            pop    = 1'b1;
                            sreg_d = rd_data;
                        end else begin
                            sreg_d = '0;
                            urun_d = 1'b1;
                            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
                        end
                    end else begin
                        // Stop lands exactly on a frame end: no further pop.
                        state_d = ST_IDLE;
                    end
                end else if ((state_q == ST_RUN) && !cfg_enable) begin
                    state_d = ST_STOP;
                end
            end
        endcase

        // Clear has priority over an underrun in the same cycle.
        if (stat_clr_underrun) begin
            urun_d = 1'b0;
            ucnt_d = '0;
        end

        if (state_d == ST_IDLE) begin
            pcnt_d = '0;
            bcnt_d = '0;
            mcnt_d = '0;
            mclk_d = 1'b0;
            sreg_d = '0;
        end
    end

    // FIFO bookkeeping. Pops come from the sequencer and are already gated by
    // the registered level, so an empty-FIFO push is kept, not forwarded.
    always_comb begin
        push     = smp_valid && ready_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Low whenever full now or next, so it stays low through the pop
        // cycle and rises one cycle after the level has dropped.
        ready_d = (level_q != LVL_FULL) && (level_d != LVL_FULL);
        dma_d   = cfg_enable && (level_q <= LVL_LOW);
    end

    always_ff @(posedge clkrst_core_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (clkrst_core_rst) begin
            state_q  <= ST_IDLE;
            pcnt_q   <= '0;
            bcnt_q   <= '0;
            mcnt_q   <= '0;
            mclk_q   <= 1'b0;
            sreg_q   <= '0;
            urun_q   <= 1'b0;
            ucnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
            dma_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            bcnt_q   <= bcnt_d;
            mcnt_q   <= mcnt_d;
            mclk_q   <= mclk_d;
            sreg_q   <= sreg_d;
            urun_q   <= urun_d;
            ucnt_q   <= ucnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
            dma_q    <= dma_d;
        end
    end

    // NOTE: storage is not reset; the pointers and level define which words are valid.
    always_ff @(posedge clkrst_core_clk) begin
        if (push) mem[wr_ptr_q] <= smp_data;
    end

    assign smp_ready       = ready_q;
    assign fifo_level      = level_q;
    assign dma_req         = dma_q;
    assign stat_running    = running;
    assign stat_underrun   = urun_q;
    assign underrun_cnt    = ucnt_q;
    assign ext_audio_mclk  = mclk_q;
    assign ext_audio_bclk  = running && (pcnt_q >= PCNT_HALF);
    assign ext_audio_lrclk = running && bcnt_q[4];
    assign ext_audio_data  = running && sreg_q[31];

endmodule

// File: tb/tb_mcpu_soc_audio_sched.sv
// ---------------------------------------------------------------------------
// tb_mcpu_soc_audio_sched
//
// Directed sequence with random sample payloads. The reference model is a
// sample queue plus the frame currently on the wire: each frame boundary
// either takes the next queued sample or plays silence and counts an underrun.
// Serial output is captured on bclk rising edges and reassembled into words.
// ---------------------------------------------------------------------------
module tb_mcpu_soc_audio_sched;

    localparam int LOW_WATER = 4;

    logic        clk = 1'b0;
    logic        rst, en, valid, clr;
    logic [31:0] sdata;
    logic        ready, dma, running, urun;
    logic [4:0]  level;
    logic [15:0] ucnt;
    logic        mclk, bclk, lrclk, sdo;

    int          n_checks = 0;
    int          n_errs   = 0;

    // Reference model state.
    logic [31:0] q[$];
    logic [31:0] cur;
    int          m_ucnt;
    bit          m_urun;

    always #5 clk = ~clk;

    mcpu_soc_audio_sched dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst   (rst),
        .cfg_enable        (en),
        .smp_valid         (valid),
        .smp_data          (sdata),
        .smp_ready         (ready),
        .fifo_level        (level),
        .dma_req           (dma),
        .stat_running      (running),
        .stat_underrun     (urun),
        .stat_clr_underrun (clr),
        .underrun_cnt      (ucnt),
        .ext_audio_mclk    (mclk),
        .ext_audio_bclk    (bclk),
        .ext_audio_lrclk   (lrclk),
        .ext_audio_data    (sdo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {3'b000, ready, level, dma, running, urun, ucnt, mclk, bclk, lrclk, sdo};
    endfunction

    // Model of one frame boundary while playing.
    task automatic model_boundary();
        if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur    = '0;
            m_urun = 1'b1;
            if (m_ucnt < 65535) m_ucnt++;
        end
    endtask

    // Capture nb serial bits, one per bclk rising edge, ending just after the
    // following bclk fall. Every wait is bounded.
    task automatic capture_bits(input int nb, output logic [31:0] bits, output logic [31:0] lrs,
                                output int clks, output int first_rise, output bit timed_out);
        int w;
        bits       = '0;
        lrs        = '0;
        clks       = 0;
        first_rise = -1;
        timed_out  = 1'b0;
        for (int i = 0; i < nb; i++) begin
            w = 0;
            while (bclk !== 1'b1 && w < 64) begin tick(); clks++; w++; end
            if (bclk !== 1'b1) begin timed_out = 1'b1; return; end
            if (first_rise < 0) first_rise = clks;
            bits = {bits[30:0], sdo};
            lrs  = {lrs[30:0], lrclk};
            w = 0;
            while (bclk !== 1'b0 && w < 64) begin tick(); clks++; w++; end
            if (bclk !== 1'b0) begin timed_out = 1'b1; return; end
        end
    endtask

    task automatic after_boundary(input string tag);
        model_boundary();
        check({tag, "_urun"}, 32'(urun), 32'(m_urun));
        check({tag, "_ucnt"}, 32'(ucnt), 32'(m_ucnt));
        check({tag, "_msb"}, 32'(sdo), 32'(cur[31]));
    endtask

    task automatic frame_check(input string tag);
        logic [31:0] b, l;
        int          c, f;
        bit          to;
        capture_bits(32, b, l, c, f, to);
        check({tag, "_timeout"}, 32'(to), 32'd0);
        check({tag, "_data"}, b, cur);
        check({tag, "_lrclk"}, l, 32'h0000_FFFF);
        after_boundary(tag);
    endtask

    initial begin
        logic [31:0] b7, l7, b25, l25, b, l, w, y;
        int          c, f, nn;
        bit          to;

        rst = 1'b1; en = 1'b0; valid = 1'b0; clr = 1'b0; sdata = '0;
        cur = '0; m_ucnt = 0; m_urun = 1'b0;

        // Reset state.
        ticks(3);
        check("reset_outputs", all_outputs(), 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", 32'(ready), 32'd1);
        check("idle_not_running", 32'(running), 32'd0);

        // Start-up: PRIME runs mclk, RUN begins once four samples are held.
        en = 1'b1;
        tick();
        check("prime_mclk_low", 32'(mclk), 32'd0);
        valid = 1'b1;
        sdata = 32'h7000_8001;
        for (int i = 0; i < 4; i++) begin
            check("prime_push_ready", 32'(ready), 32'd1);
            tick();
            q.push_back(32'h7000_8001);
        end
        valid = 1'b0;
        check("prime_mclk_high", 32'(mclk), 32'd1);
        check("prime_not_running", 32'(running), 32'd0);
        check("prime_level", 32'(level), 32'd4);
        check("prime_bclk_held", 32'(bclk), 32'd0);
        tick();
        cur = q.pop_front();
        check("run_entry_running", 32'(running), 32'd1);
        check("run_entry_level", 32'(level), 32'(q.size()));
        check("run_entry_msb", 32'(sdo), 32'(cur[31]));

        // First frame with timing.
        capture_bits(32, b, l, c, f, to);
        check("f1_timeout", 32'(to), 32'd0);
        check("f1_first_bclk_rise", 32'(f), 32'd16);
        check("f1_frame_clocks", 32'(c), 32'd1024);
        check("f1_data", b, cur);
        check("f1_lrclk", l, 32'h0000_FFFF);
        after_boundary("f1");

        // Remaining queued frames, then starvation.
        frame_check("f2");
        frame_check("f3");
        frame_check("f4");
        frame_check("f5_underrun");
        check("starve_dma", 32'(dma), 32'(q.size() <= LOW_WATER));

        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_urun = 1'b0;
        m_ucnt = 0;
        check("clr_flag", 32'(urun), 32'(m_urun));
        check("clr_count", 32'(ucnt), 32'(m_ucnt));

        // Random payload bursts against the queue model.
        for (int r = 0; r < 2; r++) begin
            nn = $urandom_range(1, 6);
            valid = 1'b1;
            for (int i = 0; i < nn; i++) begin
                w = $urandom;
                sdata = w;
                check("rnd_push_ready", 32'(ready), 32'd1);
                tick();
                q.push_back(w);
            end
            valid = 1'b0;
            tick();
            check("rnd_level", 32'(level), 32'(q.size()));
            check("rnd_dma", 32'(dma), 32'(q.size() <= LOW_WATER));
            for (int k = 0; k < nn + 1; k++) frame_check("rnd_frame");
        end

        // Push coinciding with an empty-FIFO frame boundary.
        ticks(1023);
        w = $urandom;
        sdata = w;
        valid = 1'b1;
        check("edge_push_ready", 32'(ready), 32'd1);
        tick();
        valid = 1'b0;
        model_boundary();
        q.push_back(w);
        check("edge_level", 32'(level), 32'(q.size()));
        check("edge_ucnt", 32'(ucnt), 32'(m_ucnt));
        check("edge_urun", 32'(urun), 32'(m_urun));
        check("edge_silent", 32'(sdo), 32'd0);
        tick();
        check("edge_dma", 32'(dma), 32'(q.size() <= LOW_WATER));
        frame_check("edge_silent_frame");
        frame_check("edge_kept_frame");

        // Stop mid-frame: the frame completes, leftover entries stay.
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            sdata = w;
            check("stop_push_ready", 32'(ready), 32'd1);
            tick();
            q.push_back(w);
        end
        valid = 1'b0;
        frame_check("stop_pre");
        capture_bits(7, b7, l7, c, f, to);
        check("stop_head_timeout", 32'(to), 32'd0);
        en = 1'b0;
        tick();
        check("stop_still_running", 32'(running), 32'd1);
        capture_bits(25, b25, l25, c, f, to);
        check("stop_tail_timeout", 32'(to), 32'd0);
        check("stop_frame_data", {b7[6:0], b25[24:0]}, cur);
        check("stop_idle", 32'(running), 32'd0);
        check("stop_pins", {28'd0, mclk, bclk, lrclk, sdo}, 32'd0);
        ticks(4);
        check("stop_level_kept", 32'(level), 32'(q.size()));
        check("stop_dma", 32'(dma), 32'd0);

        // Fill to full while stopped; the 17th word stalls.
        valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            w = $urandom;
            sdata = w;
            check("fill_ready", 32'(ready), 32'd1);
            tick();
            q.push_back(w);
        end
        check("full_level", 32'(level), 32'd16);
        check("full_ready", 32'(ready), 32'd0);
        y = $urandom;
        sdata = y;
        ticks(3);
        check("stall_level", 32'(level), 32'd16);
        check("stall_ready", 32'(ready), 32'd0);
        en = 1'b1;
        tick();
        check("restart_prime", 32'(running), 32'd0);
        tick();
        cur = q.pop_front();
        check("restart_run", 32'(running), 32'd1);
        check("restart_level", 32'(level), 32'(q.size()));
        check("restart_ready_low", 32'(ready), 32'd0);
        tick();
        check("restart_ready_high", 32'(ready), 32'd1);
        tick();
        q.push_back(y);
        valid = 1'b0;
        check("stalled_word_level", 32'(level), 32'(q.size()));
        check("stalled_word_ready", 32'(ready), 32'd0);
        frame_check("restart_frame");

        // Reset mid-frame at bcnt = 20.
        ticks(640);
        rst = 1'b1;
        tick();
        check("midframe_reset", all_outputs(), 32'd0);
        rst = 1'b0;
        en  = 1'b0;
        q.delete();
        tick();
        check("post_reset_level", 32'(level), 32'(q.size()));
        check("post_reset_ready", 32'(ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
